counter_updown_mod_1clk_sync_resetp: RTL
========================================

COUNTER_UPDOWN_MOD_1CLK_SYNC_RESETP -- requirements
Module: counter_updown_mod_1clk_sync_resetp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, counter width in bits (legal 2..32).
REQ-002 SHALL have parameter MAX_VALUE, default 2^WIDTH-1, upper count bound; count range 0..MAX_VALUE (legal 1..2^WIDTH-1).
REQ-003 SHALL have parameter RESET_VALUE, default 0, value loaded by reset (legal 0..MAX_VALUE).
REQ-004 SHALL have parameter SATURATE, default 0; 0 = wrap mode, 1 = saturate mode.
REQ-005 SHALL have port clock0  input  1  sole clock, all state updates on posedge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enable  input  1  count step enable.
REQ-008 SHALL have port up_down  input  1  direction: 1 = increment, 0 = decrement.
REQ-009 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-010 SHALL have port load_value  input  WIDTH  value for load.
REQ-011 SHALL have port clear_flag  input  1  clears sticky overflow flag.
REQ-012 SHALL have port count  output  WIDTH  registered counter value.
REQ-013 SHALL have port at_bound  output  1  combinational: 1 when (up_down=1 and count=MAX_VALUE) or (up_down=0 and count=0).
REQ-014 SHALL have port wrap_pulse  output  1  registered one-cycle pulse following a bound event.
REQ-015 SHALL have port overflow  output  1  registered sticky flag of bound events.

Function
REQ-016 Per-edge priority SHALL be: reset > load > enable > hold.
REQ-017 load=1: count SHALL take min(load_value, MAX_VALUE) on the next edge, regardless of enable/up_down.
REQ-018 enable=1, load=0, up_down=1, count<MAX_VALUE: count SHALL become count+1 next edge.
REQ-019 enable=1, load=0, up_down=0, count>0: count SHALL become count-1 next edge.
REQ-020 Bound event SHALL be defined as enable=1, load=0, reset=0, at_bound=1.
REQ-021 Bound event, SATURATE=0: count SHALL wrap (MAX_VALUE->0 up, 0->MAX_VALUE down).
REQ-022 Bound event, SATURATE=1: count SHALL hold its value.
REQ-023 wrap_pulse SHALL be 1 for exactly the cycle after each bound event, else 0; back-to-back events give consecutive 1s.
REQ-024 overflow SHALL set on the edge of a bound event and remain set until cleared.
REQ-025 clear_flag=1 SHALL clear overflow on the next edge; simultaneous bound event and clear_flag SHALL leave overflow=1 (set wins).
REQ-026 enable=0 and load=0: count SHALL hold; wrap_pulse SHALL be 0 next cycle.
REQ-027 Loads SHALL never produce wrap_pulse or set overflow, even when load_value>MAX_VALUE.
REQ-028 Direction change SHALL take effect on the same edge; no pipeline latency on count (1-cycle update).
REQ-029 All arithmetic SHALL be modulo-free within WIDTH bits; no intermediate overflow visible on count.

Reset
REQ-030 reset=1 at a posedge SHALL set count=RESET_VALUE, wrap_pulse=0, overflow=0, overriding load, enable, clear_flag.
REQ-031 Reset asserted mid-count SHALL take effect on the very next edge; counting resumes the edge after reset deasserts.
REQ-032 Register initial (power-up) values SHALL equal the reset values.

Verification (WIDTH=4, MAX_VALUE=9, RESET_VALUE=0 unless stated)
REQ-033 Wrap up: reset, enable=1, up_down=1 for 12 edges -> count 1..9,0,1,2; wrap_pulse=1 only in cycle after 9->0; overflow=1 thereafter.
REQ-034 Wrap down: load 2, then enable=1, up_down=0 for 4 edges -> count 2,1,0,9,8; one wrap_pulse after 0->9.
REQ-035 Saturate (SATURATE=1): count up from 7 for 5 edges -> 8,9,9,9,9; wrap_pulse=1 on three consecutive cycles; overflow=1.
REQ-036 Load clamp/priority: load=1, load_value=14, enable=1 -> count=9, wrap_pulse=0, overflow unchanged.
REQ-037 Flag: bound event and clear_flag same edge -> overflow=1; clear_flag alone next edge -> overflow=0.
REQ-038 Reset priority (RESET_VALUE=5): count=3, reset=1 with load=1, load_value=8, enable=1 -> count=5, wrap_pulse=0, overflow=0.

Source files
------------

// File: rtl/counter_updown_mod_1clk_sync_resetp.sv
// Purpose: up/down modulo counter with parallel load, bound detection, wrap pulse and sticky overflow.
// Latency: count, wrap_pulse and overflow update one clock0 edge after their inputs; at_bound is combinational.
// Backpressure: none; every input is sampled on every rising edge of clock0.
module counter_updown_mod_1clk_sync_resetp #(
  parameter int unsigned      WIDTH       = 16,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SATURATE    = 1'b0
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_flag,
  output logic [WIDTH-1:0] count,
  output logic             at_bound,
  output logic             wrap_pulse,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Power-up values match the reset values so the block is consistent before the first reset.
  logic [WIDTH-1:0] count_q = RESET_VALUE;
  logic             wrap_q  = 1'b0;
  logic             ovf_q   = 1'b0;

  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  logic             ovf_d;
  logic             bound_event;
  logic [WIDTH-1:0] load_clamped;

  // The counter sits at the edge it is currently heading towards.
  always_comb begin
    at_bound = up_down ? (count_q == MAX_VALUE) : (count_q == '0);
  end

  // Next-state: load beats counting; a step at the bound wraps or holds, never overshoots.
  always_comb begin
    load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
    bound_event  = enable & ~load & at_bound;
    count_d      = count_q;
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      if (at_bound) begin
        if (SATURATE) begin
          count_d = count_q;
        end else begin
          count_d = up_down ? '0 : MAX_VALUE;
        end
      end else begin
        count_d = up_down ? (count_q + ONE) : (count_q - ONE);
      end
    end
    wrap_d = bound_event;
    // Setting wins over clearing when both happen on the same edge.
    ovf_d  = bound_event | (ovf_q & ~clear_flag);
  end

  // State registers with synchronous reset overriding every other control.
  always_ff @(posedge clock0) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign overflow   = ovf_q;

endmodule
